// File: rtl/tx_serial_7e1_pkg.sv
// rtl/tx_serial_7e1_pkg.sv - shared 7E1 serial constants, state encodings and parity helper
package tx_serial_7e1_pkg;

  // 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  // start + 7 data + parity + stop
  localparam int FRAME_BITS = 10;

  localparam int DATA_BITS = 7;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    START    = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    STOP     = 3'd4,
    FINAL    = 3'd5
  } estado_t;

  // Even parity bit: makes the count of ones over data plus parity even
  function automatic logic paridade_par(input logic [DATA_BITS-1:0] dados);
    return ^dados;
  endfunction

endpackage

// File: rtl/tx_serial_7e1_contador_baud.sv
// rtl/tx_serial_7e1_contador_baud.sv - bit-period counter with end-of-bit tick
module contador_baud #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  // Width sized so the counter never exceeds CLKS_PER_BIT-1; at least one bit
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // End-of-bit tick on the last cycle of each bit period
  assign fim = (cnt_q == LAST);

  // Next count: clear wins, otherwise count and wrap at the tick
  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta) begin
      cnt_d = fim ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_serial_7e1.sv
// rtl/tx_serial_7e1.sv - 7E1 serial transmitter: start, 7 data LSB first, even parity, stop
module tx_serial_7e1
  import tx_serial_7e1_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados_ascii,
  output logic       saida_serial,
  output logic       pronto,
  output logic       ocupado,
  output logic [2:0] db_estado
);

  estado_t    state_q;
  estado_t    state_d;
  logic [6:0] shift_q;
  logic       par_q;
  logic [2:0] idx_q;
  logic       fim;
  logic       zera;
  logic       conta;
  logic       aceita;

  // A request is taken when idle, and also in the FINAL cycle so a held
  // partida chains frames with exactly one idle-high cycle between them
  assign aceita = partida && ((state_q == INICIAL) || (state_q == FINAL));

  // Bit timing restarts on every state change; it only runs while a bit is on the line
  assign zera  = (state_d != state_q);
  assign conta = (state_q == START) || (state_q == DADOS) ||
                 (state_q == PARIDADE) || (state_q == STOP);

  contador_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_contador_baud (
    .clock(clock),
    .reset(reset),
    .zera (zera),
    .conta(conta),
    .fim  (fim)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each line state lasts one bit period, DADOS lasts seven
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INICIAL:  if (aceita) state_d = START;
      START:    if (fim) state_d = DADOS;
      DADOS:    if (fim && (idx_q == 3'd6)) state_d = PARIDADE;
      PARIDADE: if (fim) state_d = STOP;
      STOP:     if (fim) state_d = FINAL;
      FINAL:    state_d = aceita ? START : INICIAL;
      default:  state_d = INICIAL;
    endcase
  end

  // Data path: latch the character on acceptance, shift one bit per data period
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      par_q   <= 1'b0;
      idx_q   <= '0;
    end else if (aceita) begin
      shift_q <= dados_ascii;
      par_q   <= paridade_par(dados_ascii);
      idx_q   <= '0;
    end else if ((state_q == DADOS) && fim) begin
      shift_q <= shift_q >> 1;
      idx_q   <= (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Outputs decoded from the current state only
  always_comb begin
    saida_serial = 1'b1;
    pronto       = 1'b0;
    ocupado      = 1'b0;
    unique case (state_q)
      INICIAL:  saida_serial = 1'b1;
      START:    begin saida_serial = 1'b0;       ocupado = 1'b1; end
      DADOS:    begin saida_serial = shift_q[0]; ocupado = 1'b1; end
      PARIDADE: begin saida_serial = par_q;      ocupado = 1'b1; end
      STOP:     begin saida_serial = 1'b1;       ocupado = 1'b1; end
      FINAL:    pronto = 1'b1;
      default:  saida_serial = 1'b1;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_tx_serial_7e1.sv
// tb/tb_tx_serial_7e1.sv - self-checking bench for tx_serial_7e1 against a frame-level model
module tb_tx_serial_7e1;
  import tx_serial_7e1_pkg::*;

  localparam int N_A = 434;
  localparam int N_B = 4;

  logic       clk = 1'b0;
  logic       a_reset, a_partida, a_line, a_pronto, a_ocup;
  logic [6:0] a_dados;
  logic [2:0] a_est;
  logic       b_reset, b_partida, b_line, b_pronto, b_ocup;
  logic [6:0] b_dados;
  logic [2:0] b_est;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tx_serial_7e1 #(.CLKS_PER_BIT(N_A)) dut_a (
    .clock(clk), .reset(a_reset), .partida(a_partida), .dados_ascii(a_dados),
    .saida_serial(a_line), .pronto(a_pronto), .ocupado(a_ocup), .db_estado(a_est)
  );

  tx_serial_7e1 #(.CLKS_PER_BIT(N_B)) dut_b (
    .clock(clk), .reset(b_reset), .partida(b_partida), .dados_ascii(b_dados),
    .saida_serial(b_line), .pronto(b_pronto), .ocupado(b_ocup), .db_estado(b_est)
  );

  function automatic logic line_of(input int w);
    return (w == 0) ? a_line : b_line;
  endfunction
  function automatic logic pronto_of(input int w);
    return (w == 0) ? a_pronto : b_pronto;
  endfunction
  function automatic logic ocup_of(input int w);
    return (w == 0) ? a_ocup : b_ocup;
  endfunction
  function automatic logic [2:0] est_of(input int w);
    return (w == 0) ? a_est : b_est;
  endfunction

  task automatic drive(input int w, input logic p, input logic [6:0] d);
    if (w == 0) begin a_partida = p; a_dados = d; end
    else        begin b_partida = p; b_dados = d; end
  endtask

  // Present a request, let the accepting edge pass, then scramble the data input
  task automatic start(input int w, input logic [6:0] d, input logic keep);
    drive(w, 1'b1, d);
    @(negedge clk);
    drive(w, keep, 7'($urandom));
  endtask

  // Walks one frame starting at cycle 1 after the accepting edge and ends in the pronto cycle
  task automatic check_frame(input int w, input logic [6:0] d, input int inj_k,
                             input logic [6:0] inj_d, input logic keep);
    int n;
    int ones;
    int pr_cnt;
    int oc_bad;
    logic [9:0] expb;
    logic [9:0] bad;
    logic [9:0] mid;
    logic [6:0] rx;
    n = (w == 0) ? N_A : N_B;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += d[i];
    expb[0] = 1'b0;
    for (int i = 0; i < 7; i++) expb[1+i] = d[i];
    expb[8] = (ones % 2 == 1);
    expb[9] = 1'b1;
    bad = '0; mid = '0; pr_cnt = 0; oc_bad = 0;
    for (int k = 1; k <= 10 * n; k++) begin
      int b;
      b = (k - 1) / n;
      if (line_of(w) !== expb[b]) bad[b] = 1'b1;
      if ((k - 1) % n == n / 2) mid[b] = line_of(w);
      if (pronto_of(w) !== 1'b0) pr_cnt++;
      if (ocup_of(w) !== 1'b1) oc_bad++;
      if (k == 1) begin
        checks++;
        if (est_of(w) !== START) begin
          fails++; $display("FAIL est_start w=%0d got=%0d exp=%0d", w, est_of(w), START);
        end
      end
      if (k == n + 1) begin
        checks++;
        if (est_of(w) !== DADOS) begin
          fails++; $display("FAIL est_dados w=%0d got=%0d exp=%0d", w, est_of(w), DADOS);
        end
      end
      if (k == inj_k) drive(w, 1'b1, inj_d);
      else if (k == inj_k + 1) drive(w, keep, 7'($urandom));
      @(negedge clk);
    end
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (bad[b]) begin
        fails++;
        $display("FAIL bit%0d w=%0d data=%h got_mid=%b exp=%b (not stable for %0d cycles)",
                 b, w, d, mid[b], expb[b], n);
      end
    end
    checks++;
    if (pr_cnt != 0) begin
      fails++; $display("FAIL pronto_early w=%0d got=%0d cycles exp=0", w, pr_cnt);
    end
    checks++;
    if (oc_bad != 0) begin
      fails++; $display("FAIL ocupado_frame w=%0d low_cycles=%0d exp=0", w, oc_bad);
    end
    rx = mid[7:1];
    checks++;
    if (rx !== d) begin
      fails++; $display("FAIL rx_data w=%0d got=%h exp=%h", w, rx, d);
    end
    checks++;
    if ((^mid[8:1]) !== 1'b0 || mid[0] !== 1'b0 || mid[9] !== 1'b1) begin
      fails++; $display("FAIL rx_framing w=%0d got=%b exp even parity, start 0, stop 1", w, mid);
    end
    checks++;
    if (line_of(w) !== 1'b1 || pronto_of(w) !== 1'b1 || ocup_of(w) !== 1'b0 ||
        est_of(w) !== FINAL) begin
      fails++;
      $display("FAIL final_cycle w=%0d got line=%b pronto=%b ocup=%b est=%0d exp 1 1 0 %0d",
               w, line_of(w), pronto_of(w), ocup_of(w), est_of(w), FINAL);
    end
  endtask

  task automatic check_idle(input int w, input int cycles);
    int errs;
    errs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (line_of(w) !== 1'b1 || pronto_of(w) !== 1'b0 || ocup_of(w) !== 1'b0 ||
          est_of(w) !== INICIAL) errs++;
    end
    checks++;
    if (errs != 0) begin
      fails++; $display("FAIL idle w=%0d bad_cycles=%0d exp=0", w, errs);
    end
  endtask

  task automatic test_reset;
    a_reset = 1'b1; b_reset = 1'b1;
    drive(0, 1'b1, 7'h55);
    drive(1, 1'b0, 7'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (a_line !== 1'b1 || a_pronto !== 1'b0 || a_ocup !== 1'b0 || a_est !== INICIAL) begin
      fails++;
      $display("FAIL reset_a got line=%b pronto=%b ocup=%b est=%0d exp 1 0 0 0",
               a_line, a_pronto, a_ocup, a_est);
    end
    checks++;
    if (b_line !== 1'b1 || b_pronto !== 1'b0 || b_ocup !== 1'b0 || b_est !== INICIAL) begin
      fails++;
      $display("FAIL reset_b got line=%b pronto=%b ocup=%b est=%0d exp 1 0 0 0",
               b_line, b_pronto, b_ocup, b_est);
    end
    drive(0, 1'b0, 7'h00);
    a_reset = 1'b0; b_reset = 1'b0;
    check_idle(0, 3);
  endtask

  task automatic test_frame_30;
    start(0, 7'h30, 1'b0);
    check_frame(0, 7'h30, -5, 7'h00, 1'b0);
    check_idle(0, 2);
  endtask

  task automatic test_parity_31_32;
    start(0, 7'h31, 1'b0);
    check_frame(0, 7'h31, -5, 7'h00, 1'b0);
    check_idle(0, 1);
    start(0, 7'h32, 1'b0);
    check_frame(0, 7'h32, -5, 7'h00, 1'b0);
    check_idle(0, 1);
  endtask

  task automatic test_back_to_back;
    drive(0, 1'b1, 7'h41);
    @(negedge clk);
    drive(0, 1'b1, 7'h5A);
    check_frame(0, 7'h41, -5, 7'h00, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 7'h00);
    check_frame(0, 7'h5A, -5, 7'h00, 1'b0);
    check_idle(0, 2);
  endtask

  task automatic test_partida_ignored;
    start(0, 7'h4B, 1'b0);
    check_frame(0, 7'h4B, 4 * N_A + N_A / 2, 7'h22, 1'b0);
    check_idle(0, 5);
  endtask

  task automatic test_reset_mid_frame;
    start(0, 7'h6C, 1'b0);
    repeat (2 * N_A + N_A / 2) @(negedge clk);
    a_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (a_line !== 1'b1 || a_ocup !== 1'b0 || a_pronto !== 1'b0 || a_est !== INICIAL) begin
      fails++;
      $display("FAIL reset_mid got line=%b ocup=%b pronto=%b est=%0d exp 1 0 0 0",
               a_line, a_ocup, a_pronto, a_est);
    end
    a_reset = 1'b0;
    check_idle(0, 20);
    start(0, 7'h13, 1'b0);
    check_frame(0, 7'h13, -5, 7'h00, 1'b0);
    check_idle(0, 1);
  endtask

  task automatic test_small_n;
    logic [6:0] c;
    start(1, 7'h7F, 1'b0);
    check_frame(1, 7'h7F, -5, 7'h00, 1'b0);
    check_idle(1, 2);
    for (int i = 0; i < 6; i++) begin
      c = 7'($urandom);
      start(1, c, 1'b0);
      check_frame(1, c, (i % 2 == 0) ? 13 : -5, 7'($urandom), 1'b0);
      check_idle(1, 1);
    end
  endtask

  task automatic test_random_a;
    logic [6:0] c;
    c = 7'($urandom);
    start(0, c, 1'b0);
    check_frame(0, c, -5, 7'h00, 1'b0);
    check_idle(0, 1);
  endtask

  initial begin
    a_reset = 1'b1; b_reset = 1'b1;
    a_partida = 1'b0; b_partida = 1'b0;
    a_dados = '0; b_dados = '0;
    @(negedge clk);
    test_reset;
    test_frame_30;
    test_parity_31_32;
    test_back_to_back;
    test_partida_ignored;
    test_reset_mid_frame;
    test_small_n;
    test_random_a;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
